// File: rtl/sipo_pkg.sv
// Shared constants for the serial-to-parallel deserializer (sipo_deser).
// Latency: n/a (package only).
// Backpressure: n/a.
package sipo_pkg;

    localparam int SIPO_WIDTH_DEF = 8;

    typedef logic sipo_state_t;

    localparam sipo_state_t ST_SHIFT = 1'b0;
    localparam sipo_state_t ST_PAR   = 1'b1;

    // Counter width for a count range of 0..w-1 (never narrower than 1 bit).
    function automatic int sipo_cnt_w(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/sipo_bitcnt.sv
// Sampled-bit counter 0..WIDTH-1 with final-bit detect; may hold at the last count.
// Latency: o_last is combinational from the registered count.
// Backpressure: none; advances only when i_adv=1.
module sipo_bitcnt
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_adv,
    input  logic i_hold,
    output logic o_last
);

    localparam int CW = sipo_cnt_w(WIDTH);

    logic [CW-1:0] r_cnt;

    assign o_last = (r_cnt == CW'(WIDTH - 1));

    // i_hold keeps the count at WIDTH-1 so a trailing parity bit can be sampled before wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_adv) begin
            if (o_last) begin
                if (!i_hold) begin
                    r_cnt <= '0;
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer; optional even-parity check via SIPO_PARITY_EN.
// Latency: Pout/PoutVld load on the same edge that samples the word's final bit.
// Backpressure: PoutVld/PoutRdy; a word completing while Pout is unconsumed is dropped and sets sticky Ovf.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_WIDTH_DEF,
    parameter int MSB_FIRST = 1
) (
    input  logic             C,
    input  logic             Rbar,
    input  logic             D,
    input  logic             DVld,
    output logic [WIDTH-1:0] Pout,
    output logic             PoutVld,
    input  logic             PoutRdy,
`ifdef SIPO_PARITY_EN
    output logic             ParErr,
`endif
    output logic             Ovf
);

    logic [WIDTH-1:0] r_shift;
    sipo_state_t      r_state;

    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_word;
    logic             w_last;
    logic             w_hold;
    logic             w_done;
    logic             w_load;
    logic             w_drop;

    sipo_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .i_clk   (C),
        .i_rst_n (Rbar),
        .i_adv   (DVld),
        .i_hold  (w_hold),
        .o_last  (w_last)
    );

    always_comb begin
        w_shift_nxt = r_shift;
        if (MSB_FIRST != 0) begin
            w_shift_nxt = {r_shift[WIDTH-2:0], D};
        end else begin
            w_shift_nxt = {D, r_shift[WIDTH-1:1]};
        end
    end

`ifdef SIPO_PARITY_EN
    // Data is complete in r_shift when the parity bit arrives; that edge completes the word.
    assign w_hold = (r_state == ST_SHIFT);
    assign w_done = DVld & (r_state == ST_PAR);
    assign w_word = r_shift;
`else
    assign w_hold = 1'b0;
    assign w_done = DVld & w_last & (r_state == ST_SHIFT);
    assign w_word = w_shift_nxt;
`endif

    assign w_load = w_done & (~PoutVld | PoutRdy);
    assign w_drop = w_done & PoutVld & ~PoutRdy;

    always_ff @(posedge C or negedge Rbar) begin
        if (!Rbar) begin
            r_state <= ST_SHIFT;
        end else begin
`ifdef SIPO_PARITY_EN
            if (DVld) begin
                if (r_state == ST_SHIFT) begin
                    if (w_last) begin
                        r_state <= ST_PAR;
                    end
                end else begin
                    r_state <= ST_SHIFT;
                end
            end
`else
            r_state <= ST_SHIFT;
`endif
        end
    end

    // The parity bit is never shifted in; the next word's data overwrites every position anyway.
    always_ff @(posedge C or negedge Rbar) begin
        if (!Rbar) begin
            r_shift <= '0;
        end else if (DVld && (r_state == ST_SHIFT)) begin
            r_shift <= w_shift_nxt;
        end
    end

    always_ff @(posedge C or negedge Rbar) begin
        if (!Rbar) begin
            Pout    <= '0;
            PoutVld <= 1'b0;
        end else if (w_load) begin
            Pout    <= w_word;
            PoutVld <= 1'b1;
        end else if (PoutVld && PoutRdy) begin
            PoutVld <= 1'b0;
        end
    end

    always_ff @(posedge C or negedge Rbar) begin
        if (!Rbar) begin
            Ovf <= 1'b0;
        end else if (w_drop) begin
            Ovf <= 1'b1;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge C or negedge Rbar) begin
        if (!Rbar) begin
            ParErr <= 1'b0;
        end else if (w_load) begin
            ParErr <= (^r_shift) ^ D;
        end
    end
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances share inputs and are
// compared every cycle against a queue-based word model plus directed constants.
module tb_sipo_deser;

`ifdef SIPO_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       C = 1'b0;
    logic       Rbar = 1'b0;
    logic       D = 1'b0;
    logic       DVld = 1'b0;
    logic       PoutRdy = 1'b0;
    logic [7:0] pout_m, pout_l;
    logic       vld_m, vld_l, ovf_m, ovf_l;
    logic       perr_m, perr_l;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic       mq[$];
    logic [7:0] m_msb, m_lsb;
    logic       m_vld, m_ovf, m_perr;

    always #5 C = ~C;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .C       (C),
        .Rbar    (Rbar),
        .D       (D),
        .DVld    (DVld),
        .Pout    (pout_m),
        .PoutVld (vld_m),
        .PoutRdy (PoutRdy),
`ifdef SIPO_PARITY_EN
        .ParErr  (perr_m),
`endif
        .Ovf     (ovf_m)
    );

    sipo_deser #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .C       (C),
        .Rbar    (Rbar),
        .D       (D),
        .DVld    (DVld),
        .Pout    (pout_l),
        .PoutVld (vld_l),
        .PoutRdy (PoutRdy),
`ifdef SIPO_PARITY_EN
        .ParErr  (perr_l),
`endif
        .Ovf     (ovf_l)
    );

`ifndef SIPO_PARITY_EN
    assign perr_m = 1'b0;
    assign perr_l = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_msb = '0;
        m_lsb = '0;
        m_vld = 1'b0;
        m_ovf = 1'b0;
        m_perr = 1'b0;
    endtask

    // One rising edge: collect sampled bits; a word is done after 8 (+parity) bits.
    task automatic model_edge(input logic d, input logic dv, input logic rdy);
        logic       done;
        logic [7:0] wm, wl;
        logic       pe;
        done = 1'b0;
        wm = '0;
        wl = '0;
        pe = 1'b0;
        if (dv) begin
            mq.push_back(d);
            if (mq.size() == 8 + PB) begin
                done = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    wm[7-i] = mq[i];
                    wl[i]   = mq[i];
                    pe      = pe ^ mq[i];
                end
                if (PB == 1) pe = pe ^ mq[8];
                mq.delete();
            end
        end
        if (done) begin
            if (!m_vld || rdy) begin
                m_msb = wm;
                m_lsb = wl;
                m_vld = 1'b1;
                m_perr = pe;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_vld && rdy) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".vld_m"}, 32'(vld_m), 32'(m_vld));
        chk({tag, ".vld_l"}, 32'(vld_l), 32'(m_vld));
        chk({tag, ".pout_m"}, 32'(pout_m), 32'(m_msb));
        chk({tag, ".pout_l"}, 32'(pout_l), 32'(m_lsb));
        chk({tag, ".ovf_m"}, 32'(ovf_m), 32'(m_ovf));
        chk({tag, ".ovf_l"}, 32'(ovf_l), 32'(m_ovf));
        if (PB == 1) begin
            chk({tag, ".perr_m"}, 32'(perr_m), 32'(m_perr));
            chk({tag, ".perr_l"}, 32'(perr_l), 32'(m_perr));
        end
    endtask

    task automatic step(input logic d, input logic dv, input logic rdy);
        D = d;
        DVld = dv;
        PoutRdy = rdy;
        @(posedge C);
        model_edge(d, dv, rdy);
        #1;
        check_all("step");
    endtask

    // Sends w[7] first, then the given parity bit when parity is enabled.
    task automatic send_bits(input logic [7:0] w, input logic pbit, input logic rdy);
        for (int i = 7; i >= 0; i--) step(w[i], 1'b1, rdy);
        if (PB == 1) step(pbit, 1'b1, rdy);
    endtask

    // Reset pulse placed between clock edges; outputs must clear without a clock.
    task automatic pulse_reset(input string tag);
        #2;
        Rbar = 1'b0;
        #1;
        model_reset();
        chk({tag, ".pout_m"}, 32'(pout_m), 32'h0);
        chk({tag, ".pout_l"}, 32'(pout_l), 32'h0);
        chk({tag, ".vld"}, 32'({vld_m, vld_l}), 32'h0);
        chk({tag, ".ovf"}, 32'({ovf_m, ovf_l}), 32'h0);
        chk({tag, ".perr"}, 32'({perr_m, perr_l}), 32'h0);
        #1;
        Rbar = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        chk("rst0.pout_m", 32'(pout_m), 32'h0);
        chk("rst0.vld", 32'({vld_m, vld_l}), 32'h0);
        chk("rst0.ovf", 32'({ovf_m, ovf_l}), 32'h0);
        Rbar = 1'b1;

        // 1,0,1,0,0,1,0,1 -> A5 in either bit order
        send_bits(8'hA5, ^8'hA5, 1'b1);
        chk("a5.pout_m", 32'(pout_m), 32'hA5);
        chk("a5.pout_l", 32'(pout_l), 32'hA5);
        chk("a5.vld", 32'(vld_m), 32'h1);
        step(1'b0, 1'b0, 1'b1);
        chk("a5.vld_clr", 32'(vld_m), 32'h0);

        // 1,1,0,0,0,0,0,0 -> C0 MSB-first, 03 LSB-first
        send_bits(8'hC0, ^8'hC0, 1'b1);
        chk("c0.pout_m", 32'(pout_m), 32'hC0);
        chk("c0.pout_l", 32'(pout_l), 32'h03);
        step(1'b0, 1'b0, 1'b1);

        // Backpressure: second word dropped, Ovf sticky
        send_bits(8'h11, ^8'h11, 1'b0);
        send_bits(8'h22, ^8'h22, 1'b0);
        chk("ovf.pout_m", 32'(pout_m), 32'h11);
        chk("ovf.vld", 32'(vld_m), 32'h1);
        chk("ovf.flag", 32'(ovf_m), 32'h1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("ovf.sticky", 32'(ovf_m), 32'h1);

        // Mid-word reset discards partial bits
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
        pulse_reset("rstmid");
        send_bits(8'h3C, ^8'h3C, 1'b1);
        chk("3c.pout_m", 32'(pout_m), 32'h3C);
        chk("3c.vld", 32'(vld_m), 32'h1);

        // DVld gaps between bits: only sampled bits count
        for (int i = 7; i >= 0; i--) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
            step(8'hF0 >> i, 1'b1, 1'b1);
            if (i == 1) chk("f0.early", 32'(vld_m), 32'h0);
        end
        if (PB == 1) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b1, 1'b1);
        end
        chk("f0.pout_m", 32'(pout_m), 32'hF0);
        chk("f0.pout_l", 32'(pout_l), 32'h0F);

`ifdef SIPO_PARITY_EN
        send_bits(8'h07, 1'b1, 1'b1);
        chk("par.good", 32'(perr_m), 32'h0);
        send_bits(8'h07, 1'b0, 1'b1);
        chk("par.bad", 32'(perr_m), 32'h1);
        chk("par.bad_l", 32'(perr_l), 32'h1);
`endif

        // Randomized traffic with occasional mid-stream resets
        for (int n = 0; n < 600; n++) begin
            if (n % 151 == 150) pulse_reset("rstrnd");
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
